hilo_div_unit: RTL and testbench

HILO_DIV_UNIT -- requirements
Module: hilo_div_unit

---
 rtl/hilo_div_unit.sv | 173 +++++++++++++++++
 tb/tb_hilo_div_unit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/hilo_div_unit.sv
// Iterative 32-bit HI/LO divider (DIV/DIVU): radix-2 restoring core with sign fix-up.
// Optional macro HILO_DIV_ABORT_EN adds an Abort input that cancels a divide in flight.
module hilo_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Signed,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
`ifdef HILO_DIV_ABORT_EN
    input  logic             Abort,
`endif
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             DivByZero
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   div_q, div_d;
    logic               q_neg_q, q_neg_d;
    logic               r_neg_q, r_neg_d;
    logic               dbz_pend_q, dbz_pend_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               dbz_q, dbz_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               abort_w;
    logic               accept;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     partial;
    logic [WIDTH:0]     diff;

`ifdef HILO_DIV_ABORT_EN
    assign abort_w = Abort;
`else
    assign abort_w = 1'b0;
`endif

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        state_d    = state_q;
        cnt_d      = cnt_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        div_d      = div_q;
        q_neg_d    = q_neg_q;
        r_neg_d    = r_neg_q;
        dbz_pend_d = dbz_pend_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        dbz_d      = dbz_q;

        accept  = Start && ((state_q == IDLE) || (state_q == DONE));
        a_mag   = (Signed && A[WIDTH-1]) ? (~A + WIDTH'(1)) : A;
        b_mag   = (Signed && B[WIDTH-1]) ? (~B + WIDTH'(1)) : B;
        partial = {rem_q, quo_q[WIDTH-1]};
        diff    = partial - {1'b0, div_q};

        unique case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    cnt_d = '0;
                    if (B == '0) begin
                        // Zero divisor skips the iterations; FIX then passes these through.
                        rem_d      = A;
                        quo_d      = '1;
                        div_d      = '0;
                        q_neg_d    = 1'b0;
                        r_neg_d    = 1'b0;
                        dbz_pend_d = 1'b1;
                        state_d    = FIX;
                    end else begin
                        rem_d      = '0;
                        quo_d      = a_mag;
                        div_d      = b_mag;
                        q_neg_d    = Signed & (A[WIDTH-1] ^ B[WIDTH-1]);
                        r_neg_d    = Signed & A[WIDTH-1];
                        dbz_pend_d = 1'b0;
                        dbz_d      = 1'b0;
                        state_d    = CALC;
                    end
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                if (abort_w) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_W'(WIDTH)) begin
                    // All WIDTH steps are in; this last CALC cycle only hands over to FIX.
                    state_d = FIX;
                end else begin
                    rem_d = diff[WIDTH] ? partial[WIDTH-1:0] : diff[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            FIX: begin
                if (abort_w) begin
                    state_d = IDLE;
                end else begin
                    lo_d    = q_neg_q ? (~quo_q + WIDTH'(1)) : quo_q;
                    hi_d    = r_neg_q ? (~rem_q + WIDTH'(1)) : rem_q;
                    dbz_d   = dbz_pend_q;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == CALC) || (state_d == FIX);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            div_q      <= '0;
            q_neg_q    <= 1'b0;
            r_neg_q    <= 1'b0;
            dbz_pend_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            dbz_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge value of every other flop.
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            div_q      <= div_d;
            q_neg_q    <= q_neg_d;
            r_neg_q    <= r_neg_d;
            dbz_pend_q <= dbz_pend_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            dbz_q      <= dbz_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign Busy      = busy_q;
    assign Done      = done_q;
    assign Hi        = hi_q;
    assign Lo        = lo_q;
    assign DivByZero = dbz_q;

endmodule

// File: tb/tb_hilo_div_unit.sv
// Directed bench for hilo_div_unit: expected results queued at Start, compared on Done.
module tb_hilo_div_unit;

    typedef struct {
        string       tag;
        logic [31:0] lo;
        logic [31:0] hi;
        logic        dbz;
    } exp_t;

    logic        Clk;
    logic        Reset;
    logic        Start;
    logic        Signed;
    logic [31:0] A;
    logic [31:0] B;
    logic        Busy;
    logic        Done;
    logic [31:0] Hi;
    logic [31:0] Lo;
    logic        DivByZero;
`ifdef HILO_DIV_ABORT_EN
    logic        Abort;
`endif

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] last_lo  = '0;
    logic [31:0] last_hi  = '0;

    hilo_div_unit #(.WIDTH(32)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Start     (Start),
        .Signed    (Signed),
        .A         (A),
        .B         (B),
`ifdef HILO_DIV_ABORT_EN
        .Abort     (Abort),
`endif
        .Busy      (Busy),
        .Done      (Done),
        .Hi        (Hi),
        .Lo        (Lo),
        .DivByZero (DivByZero)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every Done pulse must match the oldest queued expectation.
    always @(negedge Clk) begin
        if (Done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 64'(Done), 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.tag, "_lo"}, 64'(Lo), 64'(e.lo));
                check({e.tag, "_hi"}, 64'(Hi), 64'(e.hi));
                check({e.tag, "_dbz"}, 64'(DivByZero), 64'(e.dbz));
                last_lo = e.lo;
                last_hi = e.hi;
            end
        end
    end

    // Called just after a falling edge; the next rising edge samples the request.
    task automatic start_op(input string tag, input logic sgn, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] lo,
                            input logic [31:0] hi, input logic dbz);
        exp_t e;
        e.tag  = tag;
        e.lo   = lo;
        e.hi   = hi;
        e.dbz  = dbz;
        sb.push_back(e);
        Start  = 1'b1;
        Signed = sgn;
        A      = a;
        B      = b;
    endtask

    // k counts rising edges since the accepting edge; Busy is tallied for every cycle before Done.
    task automatic wait_done(input string tag, input int exp_lat);
        int k = 0;
        int busy_cnt = 0;
        while (!Done && k < 100) begin
            if (Busy) busy_cnt++;
            @(negedge Clk);
            k++;
        end
        check({tag, "_latency"}, 64'(k), 64'(exp_lat));
        check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(exp_lat));
    endtask

    task automatic run_op(input string tag, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] lo,
                          input logic [31:0] hi, input logic dbz, input int exp_lat);
        start_op(tag, sgn, a, b, lo, hi, dbz);
        @(posedge Clk);
        @(negedge Clk);
        Start = 1'b0;
        check({tag, "_busy_after_start"}, 64'(Busy), 64'd1);
        if (b != 32'd0) check({tag, "_dbz_cleared"}, 64'(DivByZero), 64'd0);
        wait_done(tag, exp_lat);
    endtask

    initial begin
        Reset  = 1'b0;
        Start  = 1'b0;
        Signed = 1'b0;
        A      = '0;
        B      = '0;
`ifdef HILO_DIV_ABORT_EN
        Abort  = 1'b0;
`endif
        #3;
        check("rst_busy", 64'(Busy), 64'd0);
        check("rst_done", 64'(Done), 64'd0);
        check("rst_hi", 64'(Hi), 64'd0);
        check("rst_lo", 64'(Lo), 64'd0);
        check("rst_dbz", 64'(DivByZero), 64'd0);
        @(negedge Clk);
        @(negedge Clk);

        // Start presented together with reset release: taken at the very first edge.
        Reset = 1'b1;
        run_op("udiv_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 34);
        @(negedge Clk);
        run_op("sdiv_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 34);
        run_op("sdiv_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, 34);
        run_op("sdiv_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 34);
        run_op("div_zero", 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1);
        run_op("sdiv_m100_7", 1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 34);
        run_op("udiv_big", 1'b0, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF, 32'd15, 1'b0, 34);

        // Start held high through CALC with new operands must not disturb the divide.
        start_op("start_held", 1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, 1'b0);
        @(posedge Clk);
        @(negedge Clk);
        A = 32'd9;
        B = 32'd3;
        repeat (20) @(negedge Clk);
        Start = 1'b0;
        wait_done("start_held", 14);

        // Back-to-back: a second Start issued in the Done cycle goes straight to CALC.
        run_op("b2b_first", 1'b0, 32'd50, 32'd5, 32'd10, 32'd0, 1'b0, 34);
        start_op("b2b_second", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);
        @(posedge Clk);
        @(negedge Clk);
        Start = 1'b0;
        check("b2b_busy", 64'(Busy), 64'd1);
        check("b2b_done_low", 64'(Done), 64'd0);
        wait_done("b2b_second", 34);

        // Reset at iteration 10 abandons the divide; nothing may complete afterwards.
        @(negedge Clk);
        start_op("reset_mid", 1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0);
        @(posedge Clk);
        @(negedge Clk);
        Start = 1'b0;
        repeat (10) @(negedge Clk);
        Reset = 1'b0;
        #1;
        void'(sb.pop_back());
        check("midrst_busy", 64'(Busy), 64'd0);
        check("midrst_done", 64'(Done), 64'd0);
        check("midrst_hi", 64'(Hi), 64'd0);
        check("midrst_lo", 64'(Lo), 64'd0);
        check("midrst_dbz", 64'(DivByZero), 64'd0);
        last_lo = '0;
        last_hi = '0;
        repeat (3) @(negedge Clk);
        Reset = 1'b1;
        run_op("after_reset", 1'b0, 32'd77, 32'd10, 32'd7, 32'd7, 1'b0, 34);

`ifdef HILO_DIV_ABORT_EN
        // Abort at iteration 5: back to IDLE at once, previous results kept, no Done.
        start_op("abort", 1'b0, 32'd200, 32'd3, 32'd66, 32'd2, 1'b0);
        @(posedge Clk);
        @(negedge Clk);
        Start = 1'b0;
        repeat (5) @(negedge Clk);
        Abort = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        Abort = 1'b0;
        void'(sb.pop_back());
        check("abort_busy", 64'(Busy), 64'd0);
        check("abort_done", 64'(Done), 64'd0);
        check("abort_lo_kept", 64'(Lo), 64'd7);
        check("abort_hi_kept", 64'(Hi), 64'd7);
        repeat (40) @(negedge Clk);
`endif

        // Results hold while idle and every queued expectation was consumed.
        repeat (5) @(negedge Clk);
        check("hold_lo", 64'(Lo), 64'(last_lo));
        check("hold_hi", 64'(Hi), 64'(last_hi));
        check("idle_busy", 64'(Busy), 64'd0);
        check("idle_done", 64'(Done), 64'd0);
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
